// File: rtl/aes_sbox.sv
// Registered AES forward S-box: one byte substituted per cycle, 1-cycle latency.
// Define INV_SBOX_EN to add an 'inv' input that selects the inverse S-box.
module aes_sbox (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] addr,
`ifdef INV_SBOX_EN
    input  logic       inv,
`endif
    output logic       out_valid,
    output logic [7:0] dout
);

    // Case ROM indexed by the high nibble; each row holds 16 bytes, column 0 in the MSBs.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [127:0] row;
        logic [3:0]   sel;
        sel = ~a[3:0];
        row = '0;
        case (a[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
            default: row = '0;
        endcase
        return row[{sel, 3'b000} +: 8];
    endfunction

`ifdef INV_SBOX_EN
    function automatic logic [7:0] sbox_inv(input logic [7:0] a);
        logic [127:0] row;
        logic [3:0]   sel;
        sel = ~a[3:0];
        row = '0;
        case (a[7:4])
            4'h0: row = 128'h52096ad53036a538bf40a39e81f3d7fb;
            4'h1: row = 128'h7ce339829b2fff87348e4344c4dee9cb;
            4'h2: row = 128'h547b9432a6c2233dee4c950b42fac34e;
            4'h3: row = 128'h082ea16628d924b2765ba2496d8bd125;
            4'h4: row = 128'h72f8f66486689816d4a45ccc5d65b692;
            4'h5: row = 128'h6c704850fdedb9da5e154657a78d9d84;
            4'h6: row = 128'h90d8ab008cbcd30af7e45805b8b34506;
            4'h7: row = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
            4'h8: row = 128'h3a9111414f67dcea97f2cfcef0b4e673;
            4'h9: row = 128'h96ac7422e7ad3585e2f937e81c75df6e;
            4'ha: row = 128'h47f11a711d29c5896fb7620eaa18be1b;
            4'hb: row = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
            4'hc: row = 128'h1fdda8338807c731b11210592780ec5f;
            4'hd: row = 128'h60517fa919b54a0d2de57a9f93c99cef;
            4'he: row = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
            4'hf: row = 128'h172b047eba77d626e169146355210c7d;
            default: row = '0;
        endcase
        return row[{sel, 3'b000} +: 8];
    endfunction
`endif

    logic [7:0] lookup;

    always_comb begin
`ifdef INV_SBOX_EN
        lookup = inv ? sbox_inv(addr) : sbox_fwd(addr);
`else
        lookup = sbox_fwd(addr);
`endif
    end

    // dout only updates on valid input, so an undefined addr while idle never reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dout      <= 8'h00;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                dout <= lookup;
            end
        end
    end

endmodule

// File: tb/tb_aes_sbox.sv
// Directed testbench for aes_sbox; reference S-box is rebuilt from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_aes_sbox;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] addr;
    logic       inv;
    logic       out_valid;
    logic [7:0] dout;

    int total;
    int bad;

    aes_sbox dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .addr     (addr),
`ifdef INV_SBOX_EN
        .inv      (inv),
`endif
        .out_valid(out_valid),
        .dout     (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] model_s(input logic [7:0] x);
        logic [7:0] iv;
        iv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, y[7:0]) == 8'h01) iv = y[7:0];
        end
        return iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; addr = 8'h00; inv = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        addr = 8'h01; in_valid = 1'b1;
        step();
        total++;
        if (dout !== 8'h7c || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_capture: dout=%h ov=%b want 7c/1", dout, out_valid);
        end else $display("reset_pre_capture: dout=%h ov=%b", dout, out_valid);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (dout !== 8'h00 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: dout=%h ov=%b want 00/0", dout, out_valid);
        end else $display("reset_async: dout=%h ov=%b", dout, out_valid);
        step();
        total++;
        if (dout !== 8'h00 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_held: dout=%h ov=%b want 00/0", dout, out_valid);
        end else $display("reset_held: dout=%h ov=%b", dout, out_valid);
        rst_n = 1'b1; in_valid = 1'b0; addr = 8'hff;
        repeat (3) step();
        total++;
        if (dout !== 8'h00 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: dout=%h ov=%b want 00/0", dout, out_valid);
        end else $display("reset_release_idle: dout=%h ov=%b", dout, out_valid);
    endtask

    task automatic test_single();
        logic [7:0] vin [5];
        logic [7:0] vexp [5];
        vin  = '{8'h00, 8'h01, 8'h53, 8'hc9, 8'hff};
        vexp = '{8'h63, 8'h7c, 8'hed, 8'hdd, 8'h16};
        for (int k = 0; k < 5; k++) begin
            addr = vin[k]; in_valid = 1'b1;
            step();
            total++;
            if (dout !== vexp[k] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL single_%h: dout=%h ov=%b want %h/1", vin[k], dout, out_valid, vexp[k]);
            end else $display("single_%h: dout=%h ov=%b", vin[k], dout, out_valid);
            in_valid = 1'b0; addr = ~vin[k];
            step();
            total++;
            if (dout !== vexp[k] || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL single_idle_%h: dout=%h ov=%b want %h/0", vin[k], dout, out_valid, vexp[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit seen [256];
        int distinct;
        int errs;
        logic [7:0] exp_v;
        distinct = 0;
        errs = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int i = 0; i < 256; i++) begin
            addr = i[7:0]; in_valid = 1'b1;
            step();
            exp_v = model_s(i[7:0]);
            total++;
            if (dout !== exp_v || out_valid !== 1'b1) begin
                bad++; errs++;
                $display("FAIL stream_%h: dout=%h ov=%b want %h/1", i[7:0], dout, out_valid, exp_v);
            end
            if (!$isunknown(dout) && !seen[dout]) begin
                seen[dout] = 1'b1;
                distinct++;
            end
        end
        $display("stream: 256 lookups, %0d wrong", errs);
        in_valid = 1'b0;
        step();
        total++;
        if (distinct != 256 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL stream_distinct: distinct=%0d ov=%b want 256/0", distinct, out_valid);
        end else $display("stream_distinct: distinct=%0d", distinct);
    endtask

    task automatic test_hold();
        addr = 8'h10; in_valid = 1'b1;
        step();
        total++;
        if (dout !== 8'hca || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_capture: dout=%h ov=%b want ca/1", dout, out_valid);
        end else $display("hold_capture: dout=%h ov=%b", dout, out_valid);
        in_valid = 1'b0; addr = 8'hff;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) addr = 8'hxx;
            step();
            total++;
            if (dout !== 8'hca || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL hold_%0d: dout=%h ov=%b want ca/0", k, dout, out_valid);
            end else $display("hold_%0d: dout=%h ov=%b", k, dout, out_valid);
        end
    endtask

    task automatic test_midstream_reset();
        for (int i = 0; i < 5; i++) begin
            addr = i[7:0]; in_valid = 1'b1;
            step();
        end
        total++;
        if (dout !== 8'hf2 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_before_reset: dout=%h ov=%b want f2/1", dout, out_valid);
        end else $display("mid_before_reset: dout=%h ov=%b", dout, out_valid);
        addr = 8'h05;
        rst_n = 1'b0;
        #1;
        total++;
        if (dout !== 8'h00 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_async: dout=%h ov=%b want 00/0", dout, out_valid);
        end else $display("mid_reset_async: dout=%h ov=%b", dout, out_valid);
        step();
        rst_n = 1'b1;
        addr = 8'h53; in_valid = 1'b1;
        step();
        total++;
        if (dout !== 8'hed || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_after_release: dout=%h ov=%b want ed/1", dout, out_valid);
        end else $display("mid_after_release: dout=%h ov=%b", dout, out_valid);
        in_valid = 1'b0;
        step();
    endtask

`ifdef INV_SBOX_EN
    task automatic test_inverse();
        logic [7:0] vin [4];
        logic [7:0] vexp [4];
        logic [7:0] fwd;
        int errs;
        vin  = '{8'h63, 8'hed, 8'h16, 8'h00};
        vexp = '{8'h00, 8'h53, 8'hff, 8'h52};
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            addr = vin[k]; inv = 1'b1; in_valid = 1'b1;
            step();
            total++;
            if (dout !== vexp[k] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL inv_%h: dout=%h ov=%b want %h/1", vin[k], dout, out_valid, vexp[k]);
            end else $display("inv_%h: dout=%h ov=%b", vin[k], dout, out_valid);
        end
        for (int i = 0; i < 256; i++) begin
            addr = i[7:0]; inv = 1'b0;
            step();
            fwd = model_s(i[7:0]);
            total++;
            if (dout !== fwd) begin
                bad++; errs++;
                $display("FAIL sweep_fwd_%h: dout=%h want %h", i[7:0], dout, fwd);
            end
            addr = fwd; inv = 1'b1;
            step();
            total++;
            if (dout !== i[7:0]) begin
                bad++; errs++;
                $display("FAIL sweep_inv_%h: dout=%h want %h", fwd, dout, i[7:0]);
            end
        end
        $display("inv_sweep: 512 lookups, %0d wrong", errs);
        in_valid = 1'b0; inv = 1'b0;
        step();
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_midstream_reset();
`ifdef INV_SBOX_EN
        test_inverse();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
